// File: rtl/timer_pkg.sv
// Shared types and constants for the seconds-timer command sequencer.
// Contents: opcode and FSM state enums, seconds width, status-word bit
// positions and an unsigned clamp helper for seconds operands.
package timer_pkg;

    localparam int unsigned SEC_W = 6;

    // Bit positions inside the 8-bit status word; bits [3:0] carry tmr_seconds[3:0].
    localparam int unsigned ST_FLAG_BIT = 7;
    localparam int unsigned ST_EN_BIT   = 6;
    localparam int unsigned ST_FWD_BIT  = 5;
    localparam int unsigned ST_RUN_BIT  = 4;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_LOAD         = 3'd1,
        OP_START        = 3'd2,
        OP_STOP         = 3'd3,
        OP_DIR          = 3'd4,
        OP_SET_ALARM    = 3'd5,
        OP_CLR_ALARM    = 3'd6,
        OP_STATUS_ALARM = 3'd7
    } tseq_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_RESP
    } tseq_state_e;

    function automatic logic [SEC_W-1:0] sec_clamp(input logic [SEC_W-1:0] v,
                                                   input logic [SEC_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/timer_alarm_cmp.sv
// Alarm comparator for the seconds timer.
// Fires when the running timer's seconds value newly becomes equal to the alarm value.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   alarm_en    alarm armed
//   running     timer not paused
//   busy        a load is in progress (WRITE/GAP); matches are ignored
//   seconds     current timer seconds
//   alarm_val   alarm compare value
//   clr         clear the sticky flag
//   fire        combinational match (same cycle as the qualifying seconds value)
//   flag        sticky alarm flag
//   irq         one-cycle pulse, registered from fire
module timer_alarm_cmp
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alarm_en,
    input  logic             running,
    input  logic             busy,
    input  logic [SEC_W-1:0] seconds,
    input  logic [SEC_W-1:0] alarm_val,
    input  logic             clr,
    output logic             fire,
    output logic             flag,
    output logic             irq
);

    logic [SEC_W-1:0] prev_q;
    logic             flag_q;
    logic             irq_q;

    // Edge-qualified: only the first cycle of equality counts, so a held value cannot retrigger.
    assign fire = alarm_en && running && !busy &&
                  (seconds == alarm_val) && (prev_q != alarm_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            flag_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= seconds;
            irq_q  <= fire;
            // A match in the same cycle as a clear leaves the flag set.
            if (fire) begin
                flag_q <= 1'b1;
            end else if (clr) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign flag = flag_q;
    assign irq  = irq_q;

endmodule

// File: rtl/timer_sequencer.sv
// Command sequencer for the seconds timer.
// Accepts 9-bit commands (op + arg), drives the timer data/write/pause/forward inputs,
// stretches each load into a WR_CYCLES write strobe followed by a GAP_CYCLES quiet
// period, and returns one status/response word per command.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; ready only when idle
//   cmd_op, cmd_arg            opcode and operand
//   rsp_valid, rsp_data        one-cycle response strobe and word (0 when not valid)
//   tmr_data, tmr_write        load value and write strobe to the timer
//   tmr_pause, tmr_forward     run control to the timer
//   tmr_seconds                current seconds from the timer
//   alarm_irq                  one-cycle pulse on alarm match
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int unsigned WR_CYCLES  = 3,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned SEC_MAX    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [5:0]       cmd_arg,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic [SEC_W-1:0] tmr_data,
    output logic             tmr_write,
    output logic             tmr_pause,
    output logic             tmr_forward,
    input  logic [SEC_W-1:0] tmr_seconds,
    output logic             alarm_irq
);

    localparam int unsigned CNT_MAX = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SEC_W-1:0] SEC_LIM  = SEC_W'(SEC_MAX);

    tseq_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_en_q;
    logic             rsp_alarm_q;
    logic [SEC_W-1:0] data_q, data_d;
    logic             pause_q, pause_d;
    logic             fwd_q, fwd_d;
    logic [SEC_W-1:0] aval_q, aval_d;
    logic             aen_q, aen_d;
    logic             clr;

    tseq_op_e op;
    logic     accept;
    logic     busy;
    logic     fire;
    logic     flag;
    logic     irq;

    assign op        = tseq_op_e'(cmd_op);
    // ready_en_q keeps cmd_ready low while reset is asserted.
    assign cmd_ready = (state_q == S_IDLE) && ready_en_q;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q == S_WRITE) || (state_q == S_GAP);

    // Sequencing FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (op == OP_LOAD) ? S_WRITE : S_RESP;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: written at the accept edge so the response cycle already reflects them.
    always_comb begin
        data_d  = data_q;
        pause_d = pause_q;
        fwd_d   = fwd_q;
        aval_d  = aval_q;
        aen_d   = aen_q;
        clr     = 1'b0;
        if (accept) begin
            case (op)
                OP_LOAD:      data_d  = sec_clamp(cmd_arg, SEC_LIM);
                OP_START:     pause_d = 1'b0;
                OP_STOP:      pause_d = 1'b1;
                OP_DIR:       fwd_d   = cmd_arg[0];
                OP_SET_ALARM: begin
                    aval_d = sec_clamp(cmd_arg, SEC_LIM);
                    aen_d  = 1'b1;
                end
                OP_CLR_ALARM: begin
                    aen_d = 1'b0;
                    clr   = 1'b1;
                end
                default: ;
            endcase
        end
        // Alarm auto-pause overrides a concurrent START.
        if (fire) begin
            pause_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_en_q  <= 1'b0;
            rsp_alarm_q <= 1'b0;
            data_q      <= '0;
            pause_q     <= 1'b1;
            fwd_q       <= 1'b1;
            aval_q      <= '0;
            aen_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                rsp_alarm_q <= (op == OP_STATUS_ALARM);
            end
            data_q  <= data_d;
            pause_q <= pause_d;
            fwd_q   <= fwd_d;
            aval_q  <= aval_d;
            aen_q   <= aen_d;
        end
    end

    timer_alarm_cmp u_alarm (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarm_en  (aen_q),
        .running   (!pause_q),
        .busy      (busy),
        .seconds   (tmr_seconds),
        .alarm_val (aval_q),
        .clr       (clr),
        .fire      (fire),
        .flag      (flag),
        .irq       (irq)
    );

    always_comb begin
        rsp_data = '0;
        if (state_q == S_RESP) begin
            if (rsp_alarm_q) begin
                rsp_data = {2'b00, aval_q};
            end else begin
                rsp_data[ST_FLAG_BIT] = flag;
                rsp_data[ST_EN_BIT]   = aen_q;
                rsp_data[ST_FWD_BIT]  = fwd_q;
                rsp_data[ST_RUN_BIT]  = ~pause_q;
                rsp_data[3:0]         = tmr_seconds[3:0];
            end
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign tmr_data    = data_q;
    assign tmr_write   = (state_q == S_WRITE);
    assign tmr_pause   = pause_q;
    assign tmr_forward = fwd_q;
    assign alarm_irq   = irq;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: directed scenarios plus random commands,
// compared every cycle against a timeline-based reference model.
module tb_timer_sequencer;

    localparam int WR   = 3;
    localparam int GAP  = 2;
    localparam int SMAX = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [5:0] cmd_arg;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [5:0] tmr_data;
    logic       tmr_write;
    logic       tmr_pause;
    logic       tmr_forward;
    logic [5:0] tmr_seconds;
    logic       alarm_irq;

    always #5 clk = ~clk;

    timer_sequencer #(
        .WR_CYCLES  (WR),
        .GAP_CYCLES (GAP),
        .SEC_MAX    (SMAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .tmr_data    (tmr_data),
        .tmr_write   (tmr_write),
        .tmr_pause   (tmr_pause),
        .tmr_forward (tmr_forward),
        .tmr_seconds (tmr_seconds),
        .alarm_irq   (alarm_irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: command tracked as "pending with age = edges since accept".
    bit   m_pause, m_fwd, m_aen, m_flag, m_irq, m_ready;
    int   m_aval, m_data, m_prev, m_sec;
    bit   pend, pend_load;
    int   pend_op, age;
    logic [7:0] last_rsp;

    function automatic int clampv(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    function automatic int rsp_lat();
        return pend_load ? (1 + WR + GAP) : 1;
    endfunction

    task automatic model_reset();
        m_pause = 1; m_fwd = 1; m_aen = 0; m_flag = 0; m_irq = 0; m_ready = 0;
        m_aval = 0; m_data = 0; m_prev = 0;
        pend = 0; pend_load = 0; pend_op = 0; age = 0;
    endtask

    task automatic check_outputs();
        bit exp_ready, exp_wr, exp_rv;
        logic [7:0] exp_rd;
        exp_ready = m_ready && !pend;
        exp_wr    = pend && pend_load && age >= 1 && age <= WR;
        exp_rv    = pend && age == rsp_lat();
        exp_rd    = 8'h00;
        if (exp_rv) begin
            if (pend_op == 7) exp_rd = {2'b00, 6'(m_aval)};
            else              exp_rd = {m_flag, m_aen, m_fwd, ~m_pause, 4'(m_sec)};
        end
        check_eq("cmd_ready", cmd_ready, exp_ready);
        check_eq("tmr_write", tmr_write, exp_wr);
        check_eq("rsp_valid", rsp_valid, exp_rv);
        check_eq("rsp_data", rsp_data, exp_rd);
        check_eq("tmr_data", tmr_data, m_data);
        check_eq("tmr_pause", tmr_pause, m_pause);
        check_eq("tmr_forward", tmr_forward, m_fwd);
        check_eq("alarm_irq", alarm_irq, m_irq);
        if (rsp_valid) last_rsp = rsp_data;
    endtask

    task automatic model_advance(input bit v, input int op, input int arg, input int sec);
        bit acc, busy, fire, rsp_now;
        acc     = v && m_ready && !pend;
        busy    = pend && pend_load && age >= 1 && age <= WR + GAP;
        fire    = m_aen && !m_pause && !busy && sec == m_aval && m_prev != m_aval;
        rsp_now = pend && age == rsp_lat();
        m_irq   = fire;
        m_prev  = sec;
        if (acc) begin
            case (op)
                1: m_data = clampv(arg);
                2: m_pause = 0;
                3: m_pause = 1;
                4: m_fwd = arg[0];
                5: begin m_aval = clampv(arg); m_aen = 1; end
                6: begin m_aen = 0; m_flag = 0; end
                default: ;
            endcase
        end
        if (fire) begin
            m_pause = 1;
            m_flag  = 1;
        end
        if (rsp_now) pend = 0;
        else if (pend) age++;
        if (acc) begin
            pend = 1; pend_load = (op == 1); pend_op = op; age = 1;
        end
        m_ready = 1;
    endtask

    // One clock: check this cycle's outputs, then drive inputs for the next edge.
    task automatic step(input bit v, input int op, input int arg, input int sec);
        @(negedge clk);
        check_outputs();
        cmd_valid   = v;
        cmd_op      = 3'(op);
        cmd_arg     = 6'(arg);
        tmr_seconds = 6'(sec);
        m_sec       = sec;
        model_advance(v, op, arg, sec);
    endtask

    // Issue one command and run until its response; hold keeps cmd_valid up while busy.
    task automatic send(input int op, input int arg, input int sec, input bit hold);
        int  n;
        bit  accepted;
        accepted = 0;
        n = 0;
        while (!accepted && n < 40) begin
            accepted = m_ready && !pend;
            step(1, op, arg, sec);
            n++;
        end
        while (pend && n < 40) begin
            step(hold, 0, 0, sec);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: op %0d not completed within 40 cycles", op);
        end
    endtask

    initial begin
        int sec;
        rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_arg = 0; tmr_seconds = 0;
        sec = 0; m_sec = 0; last_rsp = 0;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_tmr_pause", tmr_pause, 1);
        check_eq("rst_tmr_forward", tmr_forward, 1);
        check_eq("rst_tmr_write", tmr_write, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_tmr_data", tmr_data, 0);
        check_eq("rst_alarm_irq", alarm_irq, 0);
        @(posedge clk); #2 rst_n = 1;
        step(0, 0, 0, 0);
        @(posedge clk); #1 check_eq("ready_after_rst", cmd_ready, 1);

        // LOAD, clamp and stall behaviour
        send(1, 7, 0, 0);
        check_eq("load7_data", tmr_data, 7);
        send(1, 45, 0, 1);
        check_eq("load45_clamp", tmr_data, 9);

        // Alarm scenario
        send(5, 5, 0, 0);
        send(4, 1, 0, 0);
        send(2, 0, 0, 0);
        step(0, 0, 0, 3);
        step(0, 0, 0, 4);
        step(0, 0, 0, 5);
        @(posedge clk); #1;
        check_eq("alarm_irq_hit", alarm_irq, 1);
        check_eq("alarm_pause", tmr_pause, 1);
        step(0, 0, 0, 5);
        step(0, 0, 0, 5);
        send(0, 0, 5, 0);
        check_eq("status_flag_set", last_rsp[7], 1);
        check_eq("status_run_off", last_rsp[4], 0);
        send(6, 0, 5, 0);
        check_eq("clr_flag_en", last_rsp[7:6], 0);

        // Alarm value readback and direction
        send(5, 2, 5, 0);
        send(4, 0, 5, 0);
        send(7, 0, 5, 0);
        check_eq("status_alarm", last_rsp, 8'h02);
        send(0, 0, 5, 0);
        check_eq("status_dir0", last_rsp[5], 0);

        // Reset in the middle of a LOAD
        step(1, 1, 7, 0);
        step(0, 0, 0, 0);
        @(posedge clk); #2 rst_n = 0;
        #1;
        check_eq("midrst_write", tmr_write, 0);
        check_eq("midrst_rsp", rsp_valid, 0);
        model_reset();
        cmd_valid = 0;
        repeat (3) begin
            @(negedge clk);
            check_eq("inrst_write", tmr_write, 0);
            check_eq("inrst_rsp", rsp_valid, 0);
        end
        @(posedge clk); #2 rst_n = 1;
        send(1, 3, 0, 0);
        check_eq("load_after_rst", tmr_data, 3);

        // Random commands and seconds
        sec = 0;
        repeat (600) begin
            if ($urandom_range(0, 9) < 3) sec = $urandom_range(0, 12);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 63), sec);
        end
        repeat (10) step(0, 0, 0, sec);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
